// File: rtl/warp_scheduler_if.sv
// Bundle between the core launch/fetch/LSU side and the warp scheduler.
// The master drives launch and per-instruction status; the scheduler (slave) drives sequencing.
interface warp_scheduler_if #(
    parameter int T = 4,
    parameter int A = 8
);
    localparam int CW = $clog2(T) + 1;

    logic          start;
    logic [CW-1:0] thread_count;
    logic          fetcher_done;
    logic [T-1:0]  lsu_busy;
    logic          decoded_ret;
    logic [T*A-1:0] next_pc;
    logic [2:0]    core_state;
    logic [A-1:0]  current_pc;
    logic [T-1:0]  thread_enable;
    logic          done;

    modport master (
        output start, thread_count, fetcher_done, lsu_busy, decoded_ret, next_pc,
        input  core_state, current_pc, thread_enable, done
    );

    modport slave (
        input  start, thread_count, fetcher_done, lsu_busy, decoded_ret, next_pc,
        output core_state, current_pc, thread_enable, done
    );
endinterface

// File: rtl/warp_scheduler.sv
// Per-core instruction sequencer: walks FETCH..UPDATE, masks threads by PC match,
// reconverges diverged threads at the minimum active PC and retires threads on RET.
module warp_scheduler #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    warp_scheduler_if.slave  bus
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int CW = $clog2(T) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t         r_state, w_state_next;
    logic [A-1:0]   r_current_pc, w_current_pc_next;
    logic [T-1:0]   r_active, w_active_next;
    logic [A-1:0]   r_thread_pc      [T];
    logic [A-1:0]   w_thread_pc_next [T];
    logic           r_done, w_done_next;

    logic [T-1:0]   w_enable;
    logic [T-1:0]   w_launch_mask;
    logic [T-1:0]   w_upd_active;
    logic [A-1:0]   w_upd_pc [T];
    logic [A-1:0]   w_min_pc;
    logic           w_any_active;
    logic [CW-1:0]  w_count;

    assign w_count = (bus.thread_count > CW'(T)) ? CW'(T) : bus.thread_count;

    // Per-thread view of what UPDATE would commit; only enabled threads are touched.
    generate
        for (genvar gi = 0; gi < T; gi++) begin : g_thread
            assign w_enable[gi]      = r_active[gi] & (r_thread_pc[gi] == r_current_pc);
            assign w_launch_mask[gi] = (w_count > CW'(gi));
            assign w_upd_active[gi]  = (w_enable[gi] && bus.decoded_ret) ? 1'b0 : r_active[gi];
            assign w_upd_pc[gi]      = (w_enable[gi] && !bus.decoded_ret)
                                       ? bus.next_pc[gi*A +: A] : r_thread_pc[gi];
        end
    endgenerate

    // Reconvergence point: smallest PC among threads still alive after this UPDATE.
    always_comb begin
        w_min_pc     = '1;
        w_any_active = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (w_upd_active[i] && (!w_any_active || (w_upd_pc[i] < w_min_pc))) begin
                w_min_pc     = w_upd_pc[i];
                w_any_active = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_current_pc_next = r_current_pc;
        w_active_next     = r_active;
        w_done_next       = r_done;
        for (int i = 0; i < T; i++) w_thread_pc_next[i] = r_thread_pc[i];

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_active_next     = w_launch_mask;
                    w_current_pc_next = '0;
                    for (int i = 0; i < T; i++) w_thread_pc_next[i] = '0;
                    if (w_count == '0) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_FETCH;
                        w_done_next  = 1'b0;
                    end
                end
            end
            S_FETCH:   if (bus.fetcher_done) w_state_next = S_DECODE;
            S_DECODE:  w_state_next = S_REQUEST;
            S_REQUEST: w_state_next = S_WAIT;
            S_WAIT:    if (!(|(bus.lsu_busy & w_enable))) w_state_next = S_EXECUTE;
            S_EXECUTE: w_state_next = S_UPDATE;
            S_UPDATE: begin
                w_active_next = w_upd_active;
                for (int i = 0; i < T; i++) w_thread_pc_next[i] = w_upd_pc[i];
                if (w_any_active) begin
                    w_current_pc_next = w_min_pc;
                    w_state_next      = S_FETCH;
                end else begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_current_pc <= '0;
            r_active     <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < T; i++) r_thread_pc[i] <= '0;
        end else begin
            r_state      <= w_state_next;
            r_current_pc <= w_current_pc_next;
            r_active     <= w_active_next;
            r_done       <= w_done_next;
            for (int i = 0; i < T; i++) r_thread_pc[i] <= w_thread_pc_next[i];
        end
    end

    assign bus.core_state    = r_state;
    assign bus.current_pc    = r_current_pc;
    assign bus.thread_enable = w_enable;
    assign bus.done          = r_done;
endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: the driver queues the expected post-edge outputs of
// every cycle it drives, and a monitor pops and compares them shortly after each rising edge.
module tb_warp_scheduler;
    localparam int T  = 4;
    localparam int A  = 8;

    localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, DECODE = 3'b010, REQUEST = 3'b011;
    localparam logic [2:0] WAITS = 3'b100, EXEC = 3'b101, UPDATE = 3'b110, DONE = 3'b111;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] pc;
        logic [3:0] en;
        logic       dn;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    warp_scheduler_if #(.T(T), .A(A)) ifc ();

    warp_scheduler #(
        .THREADS_PER_BLOCK    (T),
        .PROGRAM_MEM_ADDR_BITS(A)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({ifc.core_state, ifc.current_pc, ifc.thread_enable, ifc.done} !== e) begin
                errors++;
                $display("FAIL cycle %0d: got st=%b pc=%0d en=%b done=%b, expected st=%b pc=%0d en=%b done=%b",
                         cyc, ifc.core_state, ifc.current_pc, ifc.thread_enable, ifc.done,
                         e.st, e.pc, e.en, e.dn);
            end else begin
                $display("ok   cycle %0d: st=%b pc=%0d en=%b done=%b",
                         cyc, ifc.core_state, ifc.current_pc, ifc.thread_enable, ifc.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d checks made", checks);
        $fatal(1, "timeout");
    end

    task automatic tick(input logic [2:0] st, input logic [7:0] pc, input logic [3:0] en,
                        input logic dn);
        q.push_back({st, pc, en, dn});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_instr(input int fwait, input logic [3:0] busy, input int n_drive,
                             input int n_extra, input logic ret, input logic [31:0] npc,
                             input logic [7:0] pc, input logic [3:0] en,
                             input logic [2:0] ast, input logic [7:0] apc,
                             input logic [3:0] aen, input logic adn);
        ifc.fetcher_done = 1'b0;
        repeat (fwait) tick(FETCH, pc, en, 1'b0);
        ifc.fetcher_done = 1'b1;
        tick(DECODE, pc, en, 1'b0);
        ifc.fetcher_done = 1'b0;
        tick(REQUEST, pc, en, 1'b0);
        tick(WAITS, pc, en, 1'b0);
        for (int k = 0; k <= n_extra; k++) begin
            ifc.lsu_busy = (k < n_drive) ? busy : 4'b0000;
            tick((k < n_extra) ? WAITS : EXEC, pc, en, 1'b0);
        end
        ifc.lsu_busy    = 4'b0000;
        ifc.decoded_ret = ret;
        ifc.next_pc     = npc;
        tick(UPDATE, pc, en, 1'b0);
        tick(ast, apc, aen, adn);
        ifc.decoded_ret = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [2:0] st, input logic [7:0] pc,
                             input logic [3:0] en, input logic dn);
        checks++;
        if ({ifc.core_state, ifc.current_pc, ifc.thread_enable, ifc.done} !== {st, pc, en, dn}) begin
            errors++;
            $display("FAIL %s: got st=%b pc=%0d en=%b done=%b, expected st=%b pc=%0d en=%b done=%b",
                     name, ifc.core_state, ifc.current_pc, ifc.thread_enable, ifc.done,
                     st, pc, en, dn);
        end else begin
            $display("ok   %s: st=%b pc=%0d en=%b done=%b", name, ifc.core_state,
                     ifc.current_pc, ifc.thread_enable, ifc.done);
        end
    endtask

    initial begin
        reset            = 1'b0;
        ifc.start        = 1'b0;
        ifc.thread_count = 3'd0;
        ifc.fetcher_done = 1'b0;
        ifc.lsu_busy     = 4'b0000;
        ifc.decoded_ret  = 1'b0;
        ifc.next_pc      = '0;
        #2;
        check_now("reset_state", IDLE, 8'd0, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Launch all four threads; straight-line instruction to pc 1.
        ifc.start = 1'b1; ifc.thread_count = 3'd4;
        tick(FETCH, 8'd0, 4'b1111, 1'b0);
        ifc.start = 1'b0;
        run_instr(1, 4'b0000, 0, 0, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 8'd0, 4'b1111,
                  FETCH, 8'd1, 4'b1111, 1'b0);
        // Divergence and reconvergence at pc 5.
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd5, 8'd5, 8'd2, 8'd2}, 8'd1, 4'b1111,
                  FETCH, 8'd2, 4'b0011, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd9, 8'd9, 8'd5, 8'd5}, 8'd2, 4'b0011,
                  FETCH, 8'd5, 4'b1111, 1'b0);
        // Memory stall on an enabled thread: three WAIT cycles.
        run_instr(0, 4'b0010, 2, 2, 1'b0, {8'd6, 8'd6, 8'd6, 8'd6}, 8'd5, 4'b1111,
                  FETCH, 8'd6, 4'b1111, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd20, 8'd7, 8'd7, 8'd7}, 8'd6, 4'b1111,
                  FETCH, 8'd7, 4'b0111, 1'b0);
        // Busy on a disabled thread is ignored: one WAIT cycle.
        run_instr(0, 4'b1000, 3, 0, 1'b0, {8'd0, 8'd12, 8'd10, 8'd10}, 8'd7, 4'b0111,
                  FETCH, 8'd10, 4'b0011, 1'b0);
        // RET retires t0/t1, then t2 catches up with t3, then RET on both finishes.
        run_instr(0, 4'b0000, 0, 0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd10, 4'b0011,
                  FETCH, 8'd12, 4'b0100, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd0, 8'd20, 8'd0, 8'd0}, 8'd12, 4'b0100,
                  FETCH, 8'd20, 4'b1100, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd20, 4'b1100,
                  DONE, 8'd20, 4'b0000, 1'b1);
        tick(DONE, 8'd20, 4'b0000, 1'b1);
        // Relaunch from DONE.
        ifc.start = 1'b1; ifc.thread_count = 3'd4;
        tick(FETCH, 8'd0, 4'b1111, 1'b0);
        ifc.start = 1'b0;
        // PC wrap: next_pc 0 becomes the minimum.
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd0, 4'b1111,
                  FETCH, 8'd255, 4'b1111, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd3, 8'd3, 8'd3, 8'd0}, 8'd255, 4'b1111,
                  FETCH, 8'd0, 4'b0001, 1'b0);
        // start held high through a whole instruction has no effect.
        ifc.start = 1'b1; ifc.thread_count = 3'd1;
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 8'd0, 4'b0001,
                  FETCH, 8'd3, 4'b1111, 1'b0);
        ifc.start = 1'b0;
        // Asynchronous reset in the middle of a stalled WAIT.
        ifc.fetcher_done = 1'b1;
        tick(DECODE, 8'd3, 4'b1111, 1'b0);
        ifc.fetcher_done = 1'b0;
        tick(REQUEST, 8'd3, 4'b1111, 1'b0);
        ifc.lsu_busy = 4'b1111;
        tick(WAITS, 8'd3, 4'b1111, 1'b0);
        #2 reset = 1'b0;
        #1 check_now("async_reset_in_wait", IDLE, 8'd0, 4'b0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ifc.lsu_busy = 4'b0000;
        // Zero-thread launch finishes immediately; two-thread launch masks t2/t3.
        ifc.start = 1'b1; ifc.thread_count = 3'd0;
        tick(DONE, 8'd0, 4'b0000, 1'b1);
        ifc.thread_count = 3'd2;
        tick(FETCH, 8'd0, 4'b0011, 1'b0);
        ifc.start = 1'b0;
        run_instr(0, 4'b0000, 0, 0, 1'b0, {8'd4, 8'd4, 8'd4, 8'd4}, 8'd0, 4'b0011,
                  FETCH, 8'd4, 4'b0011, 1'b0);
        run_instr(0, 4'b0000, 0, 0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd4, 4'b0011,
                  DONE, 8'd4, 4'b0000, 1'b1);
        // Oversized thread_count clamps to four threads.
        ifc.start = 1'b1; ifc.thread_count = 3'd7;
        tick(FETCH, 8'd0, 4'b1111, 1'b0);
        ifc.start = 1'b0;
        tick(FETCH, 8'd0, 4'b1111, 1'b0);

        @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
